// File: rtl/bp_pkg.sv
// Shared types for the fetch-stage branch predictor: 2-bit direction counter
// encoding, the named counter values used on reset/allocation, and the table entry view.
package bp_pkg;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } bp_cnt_e;

    localparam bp_cnt_e CNT_RESET = CNT_WNT;
    localparam bp_cnt_e CNT_JUMP  = CNT_ST;
    localparam bp_cnt_e CNT_ALLOC = CNT_WT;

    // Widest tag the table can carry (ENTRIES=4); narrower tags are zero-extended.
    localparam int MAX_TAG_W = 28;

    typedef struct packed {
        logic                 valid;
        logic [MAX_TAG_W-1:0] tag;
        logic                 jump;
        logic [31:0]          target;
        bp_cnt_e              cnt;
    } bp_entry_t;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup / execute training bus of the branch predictor.
// Statistics signals exist only when BP_STATS_EN is defined.
interface branch_predictor_if;

    logic [31:0] PCF;
    logic        BTB_validF;
    logic        BTB_jumpF;
    logic [31:0] BTB_targetF;
    logic        BHB_validF;
    logic        BHB_takenF;
    logic        flush;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_jump;
    logic        upd_taken;
    logic [31:0] upd_target;
`ifdef BP_STATS_EN
    logic        pred_takenE;
    logic [31:0] pred_targetE;
    logic [31:0] stat_ctrl;
    logic [31:0] stat_mispred;
`endif

    modport master (
        output PCF, flush, upd_en, upd_pc, upd_jump, upd_taken, upd_target,
`ifdef BP_STATS_EN
        output pred_takenE, pred_targetE,
        input  stat_ctrl, stat_mispred,
`endif
        input  BTB_validF, BTB_jumpF, BTB_targetF, BHB_validF, BHB_takenF
    );

    modport slave (
        input  PCF, flush, upd_en, upd_pc, upd_jump, upd_taken, upd_target,
`ifdef BP_STATS_EN
        input  pred_takenE, pred_targetE,
        output stat_ctrl, stat_mispred,
`endif
        output BTB_validF, BTB_jumpF, BTB_targetF, BHB_validF, BHB_takenF
    );

endinterface

// File: rtl/bp_sat_counter.sv
// Next value of a 2-bit saturating direction counter: moves one step toward
// the resolved direction and holds at either end.
module bp_sat_counter
    import bp_pkg::*;
(
    input  bp_cnt_e cnt,
    input  logic    taken,
    output bp_cnt_e cnt_next
);

    // NOTE: combinational outputs get a default first so no path can infer a latch.
    always_comb begin
        cnt_next = cnt;
        case (cnt)
            CNT_SNT: cnt_next = taken ? CNT_WNT : CNT_SNT;
            CNT_WNT: cnt_next = taken ? CNT_WT  : CNT_SNT;
            CNT_WT:  cnt_next = taken ? CNT_ST  : CNT_WNT;
            CNT_ST:  cnt_next = taken ? CNT_ST  : CNT_WT;
            default: cnt_next = cnt;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB/BHB: zero-latency lookup at PCF, trained by execute-stage resolutions.
// Optional statistics counters are built when BP_STATS_EN is defined.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64
) (
    input logic               clk,
    input logic               rstn,
    branch_predictor_if.slave bp
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] valid_q;
    bp_cnt_e            cnt_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic               jump_q   [ENTRIES];
    logic [31:0]        target_q [ENTRIES];

    logic [IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    bp_entry_t        f_e, u_e, w_e;
    logic             f_hit, u_hit, wr_en;
    bp_cnt_e          cnt_next;
    logic             unused_pc_bits;

    function automatic bp_entry_t read_entry(input logic [IDX_W-1:0] idx);
        bp_entry_t e;
        e.valid  = valid_q[idx];
        e.tag    = MAX_TAG_W'(tag_q[idx]);
        e.jump   = jump_q[idx];
        e.target = target_q[idx];
        e.cnt    = cnt_q[idx];
        return e;
    endfunction

    assign f_idx = bp.PCF[IDX_W+1:2];
    assign f_tag = bp.PCF[31:IDX_W+2];
    assign u_idx = bp.upd_pc[IDX_W+1:2];
    assign u_tag = bp.upd_pc[31:IDX_W+2];
    assign unused_pc_bits = ^{bp.PCF[1:0], bp.upd_pc[1:0]};

    assign f_e   = read_entry(f_idx);
    assign u_e   = read_entry(u_idx);
    assign f_hit = f_e.valid && (f_e.tag == MAX_TAG_W'(f_tag));
    assign u_hit = u_e.valid && (u_e.tag == MAX_TAG_W'(u_tag));

    assign bp.BTB_validF  = f_hit;
    assign bp.BTB_jumpF   = f_hit && f_e.jump;
    assign bp.BTB_targetF = f_hit ? f_e.target : 32'h0;
    assign bp.BHB_validF  = f_hit && !f_e.jump;
    assign bp.BHB_takenF  = f_hit && !f_e.jump && f_e.cnt[1];

    bp_sat_counter u_sat (
        .cnt      (u_e.cnt),
        .taken    (bp.upd_taken),
        .cnt_next (cnt_next)
    );

    // Build the complete replacement entry; unchanged fields carry the old contents.
    always_comb begin
        w_e   = u_e;
        wr_en = 1'b0;
        if (bp.upd_en && !bp.flush) begin
            if (bp.upd_jump) begin
                wr_en      = 1'b1;
                w_e.valid  = 1'b1;
                w_e.tag    = MAX_TAG_W'(u_tag);
                w_e.jump   = 1'b1;
                w_e.target = bp.upd_target;
                w_e.cnt    = CNT_JUMP;
            end else if (u_hit && !u_e.jump) begin
                wr_en   = 1'b1;
                w_e.cnt = cnt_next;
                if (bp.upd_taken) w_e.target = bp.upd_target;
            end else if (u_hit) begin
                wr_en    = 1'b1;
                w_e.jump = 1'b0;
                w_e.cnt  = bp.upd_taken ? CNT_ALLOC : CNT_WNT;
                if (bp.upd_taken) w_e.target = bp.upd_target;
            end else if (bp.upd_taken) begin
                wr_en      = 1'b1;
                w_e.valid  = 1'b1;
                w_e.tag    = MAX_TAG_W'(u_tag);
                w_e.jump   = 1'b0;
                w_e.target = bp.upd_target;
                w_e.cnt    = CNT_ALLOC;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_RESET;
        end else if (bp.flush) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[u_idx] <= w_e.valid;
            cnt_q[u_idx]   <= w_e.cnt;
        end
    end

    // NOTE: tag/jump/target are plain RAM without reset; valid_q masks them until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[u_idx]    <= TAG_W'(w_e.tag);
            jump_q[u_idx]   <= w_e.jump;
            target_q[u_idx] <= w_e.target;
        end
    end

`ifdef BP_STATS_EN
    logic        eff_taken, mispred;
    logic [31:0] stat_ctrl_q, stat_mispred_q;

    assign eff_taken = bp.upd_jump || bp.upd_taken;
    assign mispred   = (bp.pred_takenE != eff_taken) ||
                       (bp.pred_takenE && eff_taken && (bp.pred_targetE != bp.upd_target));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_ctrl_q    <= '0;
            stat_mispred_q <= '0;
        end else if (bp.upd_en && !bp.flush) begin
            if (stat_ctrl_q != '1) stat_ctrl_q <= stat_ctrl_q + 32'd1;
            if (mispred && (stat_mispred_q != '1)) stat_mispred_q <= stat_mispred_q + 32'd1;
        end
    end

    assign bp.stat_ctrl    = stat_ctrl_q;
    assign bp.stat_mispred = stat_mispred_q;
`endif

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Producer side of the fetch-stage prediction interface: owns the BTB and BHB tables.
- Serves combinational lookups at the fetch PC and is trained by resolved branches/jumps from the execute stage.
- Outputs feed fetch next-PC selection directly: BTB_validF, BTB_jumpF, BTB_targetF, BHB_validF, BHB_takenF.
- Sits beside the IF stage. The pipeline registers carrying predictions to E live outside this block.

Parameters:
- ENTRIES, 64, number of direct-mapped table entries; power of two, range 4..1024.
- IDX_W, $clog2(ENTRIES), index width; derived, not overridden.
- TAG_W, 30-IDX_W, tag width taken from PC[31:IDX_W+2].

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- PCF  in  32  fetch PC for lookup.
- BTB_validF  out  1  tag hit on a valid entry.
- BTB_jumpF  out  1  hit entry is an unconditional jump.
- BTB_targetF  out  32  stored target of hit entry.
- BHB_validF  out  1  hit entry is a conditional branch.
- BHB_takenF  out  1  counter MSB of hit branch entry.
- flush  in  1  synchronous clear of all valid bits.
- upd_en  in  1  execute stage resolves a control-flow instruction this cycle.
- upd_pc  in  32  PC of resolving instruction.
- upd_jump  in  1  1 = jal/jalr, 0 = conditional branch.
- upd_taken  in  1  actual direction; ignored for jumps, which are treated as taken.
- upd_target  in  32  actual target (PC_targetE or ALU result for jalr).

Behaviour:
- Index = PC[IDX_W+1:2]; tag = PC[31:IDX_W+2]. PC[1:0] are ignored.
- Per entry: valid, tag, jump, target[31:0], cnt[1:0].
- Lookup is purely combinational, zero latency. hit = valid[idx] && tag match.
  - BTB_validF = hit; BTB_jumpF = hit && jump.
  - BTB_targetF = target when hit, else 0.
  - BHB_validF = hit && !jump; BHB_takenF = BHB_validF && cnt[1].
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Saturating; no wrap at 00 or 11.
- Update on a clk edge with upd_en=1, flush=0:
  - Jump: write valid=1, tag, jump=1, target=upd_target, cnt=11.
  - Branch, tag hit and not jump:
    - taken: cnt+1 (saturating) and target=upd_target.
    - not taken: cnt-1 (saturating); target kept.
  - Branch, tag hit on a jump entry: overwrite as branch. cnt=10 if taken, else 01. Target written if taken.
  - Branch, miss (invalid or tag mismatch):
    - taken: allocate/replace with valid=1, jump=0, cnt=10, target=upd_target.
    - not taken: no allocation; table unchanged.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents. The update is visible from the next cycle.
- flush=1: all valid bits cleared on that edge. Flush wins over a simultaneous upd_en, whose update is dropped. Tags, targets and counters are untouched.
- Reset (rstn=0, asynchronous, may assert mid-operation): all valid=0, all cnt=01. Tags/targets need no reset. All outputs read 0 while in reset and after it until an entry is written.
- No stall input. The caller gates upd_en so each instruction trains exactly once.

Optional Feature:
- Macro BP_STATS_EN.
- When defined, adds inputs pred_takenE (1) and pred_targetE (32), and outputs stat_ctrl (32) and stat_mispred (32).
- stat_ctrl increments on every accepted update.
- stat_mispred increments when pred_takenE != effective taken, or when both are taken and pred_targetE != upd_target.
- Both counters saturate at 32'hFFFFFFFF, reset to 0 on rstn, and are not cleared by flush.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package bp_pkg holds:
  - counter encoding constants CNT_SNT/CNT_WNT/CNT_WT/CNT_ST;
  - CNT_RESET = CNT_WNT;
  - CNT_JUMP = CNT_ST;
  - CNT_ALLOC = CNT_WT;
  - the entry struct typedef.
- One sub-module, bp_sat_counter: combinational next-count function of 2-bit input and taken, with saturation. It is instantiated once on the update path.

Test Plan:
- Reset then PCF=0x100 -> all F outputs 0; all entries have cnt=01.
- Update jump upd_pc=0x100, target=0x200; next cycle PCF=0x100 -> BTB_validF=1, BTB_jumpF=1, BTB_targetF=0x200, BHB_validF=0.
- Branch 0x40 taken with target 0x80, then not-taken, not-taken, not-taken -> cnt goes 10, 01, 00, 00. BHB_takenF after each update reads 1, 0, 0, 0.
- Branch 0x44 not-taken on a miss -> BTB_validF stays 0. Then taken to 0x10 -> hit, BHB_takenF=1, target 0x10.
- Aliasing: with ENTRIES=64, train 0x100, then update taken branch 0x200 (same index) -> lookup at 0x100 misses; 0x200 hits.
- flush together with upd_en for a new PC -> every lookup misses next cycle, and no entry was written. With BP_STATS_EN: 3 updates, 1 with pred_takenE mismatch -> stat_ctrl=3, stat_mispred=1.
